// File: rtl/sram_1r1w_param_if.sv
// Client-side bundle for sram_1r1w_param: write port, read port and init status.
interface sram_1r1w_param_if #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 6
);
  logic              init_done;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              read_en;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;

  modport master (
    input  init_done, read_data, read_valid,
    output write_en, write_addr, write_data, read_en, read_addr
  );

  modport slave (
    output init_done, read_data, read_valid,
    input  write_en, write_addr, write_data, read_en, read_addr
  );
endinterface

// File: rtl/sram_1r1w_param.sv
// Behavioural 1R1W memory: registered read, write-first bypass on address
// collision, optional zero-fill of every entry after reset.
//
// state    | meaning
// ST_CLEAR | writing zero at clr_addr each cycle, client traffic dropped
// ST_READY | normal read/write service
module sram_1r1w_param #(
  parameter int DATA_W         = 2,
  parameter int ADDR_W         = 6,
  parameter int DEPTH          = 1 << ADDR_W,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic              clk,
  input logic              rst_n,
  sram_1r1w_param_if.slave bus
);
  // clr_addr is one bit wider than an index so DEPTH = 2^ADDR_W never wraps
  localparam int               CLR_W    = $clog2(DEPTH + 1);
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam state_t ST_ENTRY = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t            state_q, state_d;
  logic [CLR_W-1:0]  clr_addr_q, clr_addr_d;
  logic              init_done_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_acc, rd_acc, rd_in_range, rd_bypass;
  logic [DATA_W-1:0] read_data_q;
  logic              read_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ENTRY;
      clr_addr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (state_q == ST_CLEAR) begin
      clr_addr_d = clr_addr_q + CLR_W'(1);
      if (clr_addr_q == CLR_LAST) begin
        state_d = ST_READY;
      end
    end
  end

  // Traffic is gated on the registered init_done the client also sees
  always_comb begin
    wr_acc      = init_done_q && bus.write_en && ({1'b0, bus.write_addr} < DEPTH_X);
    rd_acc      = init_done_q && bus.read_en;
    rd_in_range = ({1'b0, bus.read_addr} < DEPTH_X);
    rd_bypass   = wr_acc && (bus.write_addr == bus.read_addr);
    mem_we      = wr_acc;
    mem_waddr   = IDX_W'(bus.write_addr);
    mem_wdata   = bus.write_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = IDX_W'(clr_addr_q);
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      read_valid_q <= rd_acc;
      if (rd_acc) begin
        if (!rd_in_range) begin
          read_data_q <= '0;
        end else if (rd_bypass) begin
          read_data_q <= bus.write_data;
        end else begin
          read_data_q <= mem[IDX_W'(bus.read_addr)];
        end
      end
    end
  end

  assign bus.init_done  = init_done_q;
  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
endmodule

// File: tb/tb_sram_1r1w_param.sv
// Scoreboard bench for sram_1r1w_param: 64x2 with clear, 40x8 non-power-of-two
// with clear, and a small 8x4 instance without clear.
module tb_sram_1r1w_param;
  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  always #5 clk = ~clk;

  sram_1r1w_param_if #(.DATA_W(2), .ADDR_W(6)) ifa ();
  sram_1r1w_param_if #(.DATA_W(8), .ADDR_W(6)) ifb ();
  sram_1r1w_param_if #(.DATA_W(4), .ADDR_W(3)) ifc ();

  sram_1r1w_param #(.DATA_W(2), .ADDR_W(6), .DEPTH(64), .CLEAR_ON_RESET(1))
    dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa.slave));
  sram_1r1w_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(40), .CLEAR_ON_RESET(1))
    dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb.slave));
  sram_1r1w_param #(.DATA_W(4), .ADDR_W(3), .DEPTH(8), .CLEAR_ON_RESET(0))
    dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc.slave));

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference contents: an array updated write-first, reads answered from it
  logic [1:0] mem_a [64];
  logic [7:0] mem_b [40];
  logic [1:0] q_a [$];
  logic [7:0] q_b [$];
  logic [1:0] last_a, exp_a;
  logic [7:0] last_b, exp_b;

  task automatic zero_a();
    for (int i = 0; i < 64; i++) mem_a[i] = '0;
  endtask

  task automatic zero_b();
    for (int i = 0; i < 40; i++) mem_b[i] = '0;
  endtask

  task automatic drive_a(input logic we, input logic [5:0] wa, input logic [1:0] wd,
                         input logic re, input logic [5:0] ra);
    ifa.write_en = we; ifa.write_addr = wa; ifa.write_data = wd;
    ifa.read_en  = re; ifa.read_addr  = ra;
    if (rst_a && ifa.init_done) begin
      if (we) mem_a[wa] = wd;
      if (re) q_a.push_back(mem_a[ra]);
    end
    @(negedge clk);
  endtask

  task automatic drive_b(input logic we, input logic [5:0] wa, input logic [7:0] wd,
                         input logic re, input logic [5:0] ra);
    ifb.write_en = we; ifb.write_addr = wa; ifb.write_data = wd;
    ifb.read_en  = re; ifb.read_addr  = ra;
    if (rst_b && ifb.init_done) begin
      if (we && wa < 40) mem_b[wa] = wd;
      if (re) q_b.push_back((ra < 40) ? mem_b[ra] : 8'h00);
    end
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst_a) begin
      chk("a_rst_valid", 32'(ifa.read_valid), 0);
      chk("a_rst_data", 32'(ifa.read_data), 0);
      chk("a_rst_init", 32'(ifa.init_done), 0);
      last_a = '0;
      q_a.delete();
    end else if (q_a.size() != 0) begin
      exp_a = q_a.pop_front();
      chk("a_read_valid", 32'(ifa.read_valid), 1);
      chk("a_read_data", 32'(ifa.read_data), 32'(exp_a));
      last_a = exp_a;
    end else begin
      chk("a_idle_valid", 32'(ifa.read_valid), 0);
      chk("a_hold_data", 32'(ifa.read_data), 32'(last_a));
    end
  end

  always @(posedge clk) begin
    #1;
    if (!rst_b) begin
      chk("b_rst_valid", 32'(ifb.read_valid), 0);
      chk("b_rst_data", 32'(ifb.read_data), 0);
      chk("b_rst_init", 32'(ifb.init_done), 0);
      last_b = '0;
      q_b.delete();
    end else if (q_b.size() != 0) begin
      exp_b = q_b.pop_front();
      chk("b_read_valid", 32'(ifb.read_valid), 1);
      chk("b_read_data", 32'(ifb.read_data), 32'(exp_b));
      last_b = exp_b;
    end else begin
      chk("b_idle_valid", 32'(ifb.read_valid), 0);
      chk("b_hold_data", 32'(ifb.read_data), 32'(last_b));
    end
  end

  initial begin
    logic [5:0] wa, ra;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    ifa.write_en = 0; ifa.write_addr = '0; ifa.write_data = '0; ifa.read_en = 0; ifa.read_addr = '0;
    ifb.write_en = 0; ifb.write_addr = '0; ifb.write_data = '0; ifb.read_en = 0; ifb.read_addr = '0;
    ifc.write_en = 0; ifc.write_addr = '0; ifc.write_data = '0; ifc.read_en = 0; ifc.read_addr = '0;
    repeat (3) @(negedge clk);

    // 64-entry clear, with a write and read to addr 5 in clear cycle 3
    rst_a = 1'b1; zero_a();
    for (int k = 1; k <= 64; k++) begin
      drive_a(k == 3, 6'd5, 2'b11, k == 3, 6'd5);
      chk("a_init_done", 32'(ifa.init_done), 32'(k == 64));
    end
    for (int i = 0; i < 64; i++) drive_a(1'b0, 6'd0, 2'd0, 1'b1, 6'(i));
    drive_a(1'b0, 6'd0, 2'd0, 1'b1, 6'd5);
    drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);

    // write-first collision
    drive_a(1'b1, 6'd10, 2'b01, 1'b0, 6'd0);
    drive_a(1'b1, 6'd10, 2'b10, 1'b1, 6'd10);
    drive_a(1'b0, 6'd0, 2'd0, 1'b1, 6'd10);
    repeat (2) drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);

    // streaming reads of a mod-4 pattern
    for (int i = 0; i < 64; i++) drive_a(1'b1, 6'(i), 2'(i % 4), 1'b0, 6'd0);
    for (int i = 0; i < 64; i++) drive_a(1'b0, 6'd0, 2'd0, 1'b1, 6'(i));
    repeat (2) drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);

    for (int n = 0; n < 300; n++) begin
      wa = 6'($urandom_range(0, 63));
      ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      drive_a(1'($urandom_range(0, 1)), wa, 2'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    repeat (2) drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);

    // reset at clear cycle 30: the full 64-edge clear must repeat
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1; zero_a();
    for (int k = 1; k <= 29; k++) begin
      drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);
      chk("a_midclear_init", 32'(ifa.init_done), 0);
    end
    rst_a = 1'b0;
    repeat (2) drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);
    rst_a = 1'b1; zero_a();
    for (int k = 1; k <= 64; k++) begin
      drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);
      chk("a_reclear_init", 32'(ifa.init_done), 32'(k == 64));
    end
    for (int i = 0; i < 64; i++) drive_a(1'b0, 6'd0, 2'd0, 1'b1, 6'(i));
    repeat (2) drive_a(1'b0, 6'd0, 2'd0, 1'b0, 6'd0);

    // 40 x 8 with out-of-range addresses
    rst_b = 1'b1; zero_b();
    for (int k = 1; k <= 40; k++) begin
      drive_b(1'b0, 6'd0, 8'd0, 1'b0, 6'd0);
      chk("b_init_done", 32'(ifb.init_done), 32'(k == 40));
    end
    drive_b(1'b1, 6'd45, 8'hAA, 1'b0, 6'd0);
    drive_b(1'b0, 6'd0, 8'h00, 1'b1, 6'd45);
    drive_b(1'b1, 6'd45, 8'hAA, 1'b1, 6'd45);
    drive_b(1'b1, 6'd39, 8'h5C, 1'b0, 6'd0);
    drive_b(1'b0, 6'd0, 8'h00, 1'b1, 6'd39);
    drive_b(1'b1, 6'd39, 8'hC5, 1'b1, 6'd39);
    drive_b(1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
    for (int n = 0; n < 300; n++) begin
      wa = 6'($urandom_range(0, 63));
      ra = ($urandom_range(0, 3) == 0) ? wa : 6'($urandom_range(0, 63));
      drive_b(1'($urandom_range(0, 1)), wa, 8'($urandom), 1'($urandom_range(0, 1)), ra);
    end
    repeat (2) drive_b(1'b0, 6'd0, 8'd0, 1'b0, 6'd0);

    // no-clear instance: ready one edge after release
    chk("c_rst_init", 32'(ifc.init_done), 0);
    rst_c = 1'b1;
    @(negedge clk);
    chk("c_init_done", 32'(ifc.init_done), 1);
    ifc.write_en = 1'b1; ifc.write_addr = 3'd2; ifc.write_data = 4'h9;
    @(negedge clk);
    ifc.write_en = 1'b0; ifc.read_en = 1'b1; ifc.read_addr = 3'd2;
    @(negedge clk);
    ifc.read_en = 1'b0;
    chk("c_read_valid", 32'(ifc.read_valid), 1);
    chk("c_read_data", 32'(ifc.read_data), 32'h9);
    @(negedge clk);
    chk("c_idle_valid", 32'(ifc.read_valid), 0);
    chk("c_hold_data", 32'(ifc.read_data), 32'h9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
